fetch_ctrl: RTL and testbench

- Front-end sequencer: owns the architectural fetch PC and emits up to FETCH_W consecutive fetch addresses to the instruction cache each cycle.
- Sizes each fetch group by instruction-buffer and ROB credits, allocates ROB tags, and aligns the tag base and valid mask with the registered decode stage.
- Handles branch-unit redirects by squashing the in-flight decode group and rewinding the ROB tail.

---
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl.sv | 99 +++++++++
 tb/tb_fetch_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus: branch redirect and credit inputs, icache fetch group
// and decode-stage outputs. fetch_ctrl connects on the master modport.
interface fetch_ctrl_if;
   logic        is_jump;
   logic [15:0] jump_target;
   logic [3:0]  jump_rob_idx;
   logic [3:0]  ibuf_free;
   logic [4:0]  rob_free;
   logic [63:0] fetch_pc;
   logic [3:0]  fetch_valid;
   logic [2:0]  num_fetch;
   logic [3:0]  dec_valid;
   logic [3:0]  dec_rob_base;
   logic        squash;
   logic [15:0] stall_cnt;

   modport master (
      input  is_jump, jump_target, jump_rob_idx, ibuf_free, rob_free,
      output fetch_pc, fetch_valid, num_fetch, dec_valid, dec_rob_base, squash, stall_cnt
   );

   modport slave (
      output is_jump, jump_target, jump_rob_idx, ibuf_free, rob_free,
      input  fetch_pc, fetch_valid, num_fetch, dec_valid, dec_rob_base, squash, stall_cnt
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: owns the fetch PC, sizes each group by ibuf/ROB
// credits, allocates ROB tags and squashes the decode group on redirects.
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic          clk,
   input logic          rst_n,
   fetch_ctrl_if.master bus
);
   localparam int FETCH_W = 4;
   localparam int PC_W    = 16;
   localparam int TAG_W   = 4;

   typedef enum logic [1:0] {IDLE, RUN, HOLD, REDIRECT} state_t;

   state_t             state, state_nxt;
   logic [PC_W-1:0]    pc;
   logic [TAG_W-1:0]   tail;
   logic [FETCH_W-1:0] dec_valid;
   logic [TAG_W-1:0]   dec_rob_base;
   logic               squash;
   logic [15:0]        stall_cnt;

   logic               jump_taken;
   logic [4:0]         credit;
   logic [2:0]         n;
   logic [FETCH_W-1:0] fetch_valid;
   logic [63:0]        fetch_pc;

   // Redirects are only honoured once the sequencer has left IDLE.
   assign jump_taken = (state != IDLE) && bus.is_jump;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      credit = {1'b0, bus.ibuf_free};
      if (bus.rob_free < credit) credit = bus.rob_free;
      if (credit > 5'd4)         credit = 5'd4;
      n = ((state != IDLE) && !bus.is_jump) ? credit[2:0] : 3'd0;

      fetch_valid = '0;
      fetch_pc    = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         fetch_valid[i]        = (3'(i) < n);
         fetch_pc[16*i +: 16]  = pc + PC_W'(2 * i);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = RUN;
         default: begin
            if (bus.is_jump)  state_nxt = REDIRECT;
            else if (n == 0)  state_nxt = HOLD;
            else              state_nxt = RUN;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         tail         <= '0;
         dec_valid    <= '0;
         dec_rob_base <= '0;
         squash       <= 1'b0;
         stall_cnt    <= '0;
      end else begin
         state  <= state_nxt;
         squash <= 1'b0;
         if (jump_taken) begin
            pc        <= bus.jump_target;
            tail      <= bus.jump_rob_idx + TAG_W'(1);
            squash    <= 1'b1;
            dec_valid <= '0;
         end else if (n != 0) begin
            pc           <= pc + PC_W'({n, 1'b0});
            tail         <= tail + TAG_W'(n);
            dec_rob_base <= tail;
            dec_valid    <= fetch_valid;
         end else begin
            dec_valid <= '0;
         end
         // Counted on the edge into each HOLD cycle, so the value seen in HOLD includes it.
         if (state_nxt == HOLD && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign bus.fetch_pc     = fetch_pc;
   assign bus.fetch_valid  = fetch_valid;
   assign bus.num_fetch    = n;
   assign bus.dec_valid    = dec_valid;
   assign bus.dec_rob_base = dec_rob_base;
   assign bus.squash       = squash;
   assign bus.stall_cnt    = stall_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_fetch_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fetch_ctrl_if bus ();

   fetch_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [3:0]  fv;
      logic [15:0] pc0;
      logic [3:0]  dv;
      logic [3:0]  base;
      logic        sq;
      logic [15:0] stall;
   } exp_t;

   exp_t exp_q[$];
   int   stim_cyc = 0;
   int   mon_cyc  = 0;
   int   n_total  = 0;
   int   n_pass   = 0;
   logic done     = 1'b0;

   always @(posedge clk)
      if (rst_n) begin
         assert (bus.ibuf_free <= 4'd8) else $error("illegal ibuf_free %0d", bus.ibuf_free);
         assert (bus.rob_free <= 5'd16) else $error("illegal rob_free %0d", bus.rob_free);
      end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, mon_cyc, act, exp);
   endtask

   // Monitor: compares every queued expectation stamped for the current cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] exp_pc;
      mon_cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc == mon_cyc) begin
         e = exp_q.pop_front();
         for (int i = 0; i < 4; i++) exp_pc[16*i +: 16] = e.pc0 + 16'(2 * i);
         check("fetch_valid",  64'(bus.fetch_valid),  64'(e.fv));
         check("num_fetch",    64'(bus.num_fetch),    64'($countones(e.fv)));
         check("fetch_pc",     bus.fetch_pc,          exp_pc);
         check("dec_valid",    64'(bus.dec_valid),    64'(e.dv));
         check("dec_rob_base", 64'(bus.dec_rob_base), 64'(e.base));
         check("squash",       64'(bus.squash),       64'(e.sq));
         check("stall_cnt",    64'(bus.stall_cnt),    64'(e.stall));
      end
      if (done) begin
         check("queue_drained", 64'(exp_q.size()), 64'd0);
         $display("%0d/%0d checks passed", n_pass, n_total);
         $finish;
      end
   end

   task automatic cyc(input logic rst, input logic jmp, input logic [15:0] tgt,
                      input logic [3:0] idx, input logic [3:0] ib, input logic [4:0] rb,
                      input logic [3:0] fv, input logic [15:0] pc0, input logic [3:0] dv,
                      input logic [3:0] base, input logic sq, input logic [15:0] st);
      exp_t e;
      @(posedge clk);
      #1;
      stim_cyc++;
      rst_n            = rst;
      bus.is_jump      = jmp;
      bus.jump_target  = tgt;
      bus.jump_rob_idx = idx;
      bus.ibuf_free    = ib;
      bus.rob_free     = rb;
      e.cyc = stim_cyc; e.fv = fv; e.pc0 = pc0; e.dv = dv;
      e.base = base; e.sq = sq; e.stall = st;
      exp_q.push_back(e);
   endtask

   initial begin
      bus.is_jump      = 1'b0;
      bus.jump_target  = 16'h0000;
      bus.jump_rob_idx = 4'd0;
      bus.ibuf_free    = 4'd8;
      bus.rob_free     = 5'd16;
      //   rst jmp tgt       idx ibuf rob | fv     pc0       dv     base sq stall
      cyc(0, 0, 16'h0000, 0, 8, 16, 4'h0, 16'h0000, 4'h0, 0,  0, 0); // in reset
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'h0, 16'h0000, 4'h0, 0,  0, 0); // IDLE
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'hF, 16'h0000, 4'h0, 0,  0, 0); // first group
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'hF, 16'h0008, 4'hF, 0,  0, 0);
      cyc(1, 0, 16'h0000, 0, 2, 16, 4'h3, 16'h0010, 4'hF, 4,  0, 0); // ibuf limit
      cyc(1, 0, 16'h0000, 0, 8, 1,  4'h1, 16'h0014, 4'h3, 8,  0, 0); // rob limit
      cyc(1, 0, 16'h0000, 0, 0, 16, 4'h0, 16'h0016, 4'h1, 10, 0, 0); // stall begins
      cyc(1, 0, 16'h0000, 0, 0, 16, 4'h0, 16'h0016, 4'h0, 10, 0, 1);
      cyc(1, 0, 16'h0000, 0, 0, 16, 4'h0, 16'h0016, 4'h0, 10, 0, 2);
      cyc(1, 0, 16'h0000, 0, 0, 16, 4'h0, 16'h0016, 4'h0, 10, 0, 3);
      cyc(1, 0, 16'h0000, 0, 0, 16, 4'h0, 16'h0016, 4'h0, 10, 0, 4);
      cyc(1, 0, 16'h0000, 0, 4, 16, 4'hF, 16'h0016, 4'h0, 10, 0, 5); // resume at held pc
      cyc(1, 1, 16'h0100, 5, 8, 16, 4'h0, 16'h001E, 4'hF, 11, 0, 5); // jump from RUN
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'hF, 16'h0100, 4'h0, 11, 1, 5); // REDIRECT
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'hF, 16'h0108, 4'hF, 6,  0, 5);
      cyc(1, 1, 16'h2000, 3, 8, 16, 4'h0, 16'h0110, 4'hF, 10, 0, 5); // jump
      cyc(1, 1, 16'hFFFC, 13, 8, 16, 4'h0, 16'h2000, 4'h0, 10, 1, 5); // jump in REDIRECT
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'hF, 16'hFFFC, 4'h0, 10, 1, 5); // pc wrap group
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'hF, 16'h0004, 4'hF, 14, 0, 5);
      cyc(1, 0, 16'h0000, 0, 0, 16, 4'h0, 16'h000C, 4'hF, 2,  0, 5); // tail wrapped to 2
      cyc(0, 1, 16'h0500, 7, 0, 16, 4'h0, 16'h000C, 4'h0, 2,  0, 6); // reset in HOLD + jump
      cyc(1, 1, 16'h0500, 7, 8, 16, 4'h0, 16'h0000, 4'h0, 0,  0, 0); // jump ignored in IDLE
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'hF, 16'h0000, 4'h0, 0,  0, 0);
      cyc(1, 0, 16'h0000, 0, 8, 16, 4'hF, 16'h0008, 4'hF, 0,  0, 0);
      @(posedge clk);
      #1;
      done = 1'b1;
      repeat (10) @(posedge clk);
      $display("FAIL monitor_timeout: summary not reached, %0d of %0d checks passed", n_pass, n_total);
      $fatal(1, "monitor did not terminate");
   end
endmodule
